// File: rtl/i2s_pkg.sv
// i2s_pkg -- definitions shared by the I2S transmitter and receiver.
//   DW_DEFAULT          default sample width per channel
//   I2S_STD / I2S_LJ    ws_align encodings (standard I2S / left-justified)
//   CH_LEFT / CH_RIGHT  word-select channel encodings
//   ws_for_bit()        word-select level for a frame bit position
package i2s_pkg;

  localparam int   DW_DEFAULT = 16;

  localparam logic I2S_STD  = 1'b0;
  localparam logic I2S_LJ   = 1'b1;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Word-select level while bit bit_idx of a 2*dw-bit frame is on the wire.
  // Standard I2S switches one bit earlier than left-justified.
  function automatic logic ws_for_bit(input int bit_idx, input int dw, input logic align);
    if (align == I2S_LJ)
      return (bit_idx >= dw) ? CH_RIGHT : CH_LEFT;
    else
      return (bit_idx >= dw - 1 && bit_idx < 2 * dw - 1) ? CH_RIGHT : CH_LEFT;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen -- bit-clock divider for the I2S transmitter.
// Ports:
//   clk       system clock (rising edge)
//   rst       synchronous active-high reset
//   i2s_clk   bit clock, toggles every CLK_DIV clk cycles
//   fall_evt  high in the cycle whose closing clk edge takes i2s_clk 1->0
module i2s_bclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic i2s_clk,
  output logic fall_evt
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);
  // Combinational so that framing logic updates on the same edge as the fall.
  assign fall_evt = div_wrap && i2s_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      i2s_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      i2s_clk <= ~i2s_clk;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx -- I2S / left-justified serial audio transmitter.
// A one-deep holding register accepts a left/right pair; each frame start moves
// it into a 2*DW shift register that is sent MSB first, data changing on the
// falling edge of i2s_clk.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   left_data, right_data    sample pair, offered with dvalid
//   dvalid / ready           pair handshake (ready = holding register empty)
//   ws_align                 0 = standard I2S, 1 = left-justified (latched per frame)
//   i2s_clk, i2s_ws, i2s_dout  serial bus
//   underrun                 one-cycle pulse when a frame starts with nothing held
// Build option: I2S_TX_UNDERRUN_MUTE_EN -- an underrun frame is sent as zeros
// instead of repeating the last accepted pair.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int CLK_DIV = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] left_data,
  input  logic [DW-1:0] right_data,
  input  logic          dvalid,
  output logic          ready,
  input  logic          ws_align,
  output logic          i2s_clk,
  output logic          i2s_ws,
  output logic          i2s_dout,
  output logic          underrun
);

  localparam int            FW       = 2 * DW;
  localparam int            BW       = $clog2(FW);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);

  logic          fall_evt;
  logic          frame_start;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nxt;
  logic [FW-1:0] shreg;
  logic [FW-1:0] hold;
  logic [FW-1:0] load_val;
  logic          full;
  logic          ws_lat;
  logic          align_nxt;

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .clk      (clk),
    .rst      (rst),
    .i2s_clk  (i2s_clk),
    .fall_evt (fall_evt)
  );

  assign frame_start = fall_evt && (bit_cnt == BIT_LAST);
  assign bit_nxt     = frame_start ? '0 : bit_cnt + BW'(1);
  // A new frame takes the live ws_align; otherwise the frame keeps its latched value.
  assign align_nxt   = frame_start ? ws_align : ws_lat;
  assign ready       = !full;
  assign i2s_dout    = shreg[FW-1];

`ifdef I2S_TX_UNDERRUN_MUTE_EN
  assign load_val = full ? hold : '0;
`else
  // hold keeps the last accepted pair after it is consumed, so an underrun repeats it.
  assign load_val = hold;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= BIT_LAST;
      shreg    <= '0;
      hold     <= '0;
      full     <= 1'b0;
      ws_lat   <= I2S_STD;
      i2s_ws   <= CH_LEFT;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start && !full;

      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        ws_lat  <= align_nxt;
        i2s_ws  <= ws_for_bit(int'(bit_nxt), DW, align_nxt);
        shreg   <= frame_start ? load_val : {shreg[FW-2:0], 1'b0};
      end

      // When full, ready is low, so a frame start emptying the register never
      // collides with a capture; an accept on a frame start refills it.
      if (dvalid && !full) begin
        full <= 1'b1;
        hold <= {left_data, right_data};
      end else if (frame_start) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

  localparam int DW    = 16;
  localparam int CD    = 2;
  localparam int FW    = 2 * DW;
  localparam int FRAME = FW * 2 * CD;
  localparam int FIRST = 2 * CD - 1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] left_data = '0;
  logic [DW-1:0] right_data = '0;
  logic          dvalid = 1'b0;
  logic          ws_align = 1'b1;
  logic          ready, i2s_clk, i2s_ws, i2s_dout, underrun;

  always #5 clk = ~clk;

  i2s_tx #(.DW(DW), .CLK_DIV(CD)) dut (
    .clk        (clk),
    .rst        (rst),
    .left_data  (left_data),
    .right_data (right_data),
    .dvalid     (dvalid),
    .ready      (ready),
    .ws_align   (ws_align),
    .i2s_clk    (i2s_clk),
    .i2s_ws     (i2s_ws),
    .i2s_dout   (i2s_dout),
    .underrun   (underrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: frames start every FRAME cycles from edge FIRST after reset;
  // one pending pair at most; a frame sends the pending pair, else zeros/last pair.
  typedef struct {
    logic [FW-1:0] data;
    logic          align;
  } frame_t;

  frame_t        frame_q[$];
  frame_t        f_new;
  int            n = -1;
  logic          pend = 1'b0;
  logic [FW-1:0] pend_pair = '0;
  logic [FW-1:0] last_pair = '0;
  logic          exp_und = 1'b0;
  logic          rst_seen = 1'b0;
  logic          acc, fs;

  always @(posedge clk) begin
    if (rst) begin
      n = -1;
      pend = 1'b0;
      pend_pair = '0;
      last_pair = '0;
      exp_und = 1'b0;
      frame_q.delete();
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      n++;
      acc = dvalid && !pend;
      fs = (n >= FIRST) && ((n - FIRST) % FRAME == 0);
      exp_und = fs && !pend;
      if (fs) begin
        f_new.data  = pend ? pend_pair : (MUTE ? '0 : last_pair);
        f_new.align = ws_align;
        frame_q.push_back(f_new);
        pend = 1'b0;
      end
      if (acc) begin
        pend = 1'b1;
        pend_pair = {left_data, right_data};
        last_pair = pend_pair;
      end
    end
  end

  // Receiver / checker: samples the bus on each predicted i2s_clk rise.
  frame_t        cur;
  logic          have_cur = 1'b0;
  logic [FW-1:0] rx_d = '0;
  logic [FW-1:0] rx_w = '0;
  int            b;

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("rst_i2s_clk", i2s_clk, 0);
      chk("rst_ws", i2s_ws, 0);
      chk("rst_dout", i2s_dout, 0);
      chk("rst_ready", ready, 1);
      chk("rst_underrun", underrun, 0);
      have_cur = 1'b0;
    end else if (n >= 0) begin
      chk("bclk", i2s_clk, ((n + 1) / CD) % 2);
      chk("ready", ready, !pend);
      chk("underrun", underrun, exp_und);
      if (n > FIRST && (n + 1) % (2 * CD) == CD) begin
        b = ((n - FIRST) / (2 * CD)) % FW;
        if (b == 0) begin
          have_cur = frame_q.size() > 0;
          if (have_cur) cur = frame_q.pop_front();
        end
        rx_d[FW-1-b] = i2s_dout;
        rx_w[FW-1-b] = i2s_ws;
        if (b == FW - 1 && have_cur) begin
          chk("frame_data", rx_d, cur.data);
          chk("frame_ws", rx_w, cur.align ? 32'h0000_FFFF : 32'h0001_FFFE);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Fixed pair, left-justified, then idle frames (underrun behaviour).
    left_data = 16'hA5C3; right_data = 16'h0F0F; ws_align = 1'b1; dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    repeat (3 * FRAME) @(negedge clk);

    // Same pair in standard I2S framing.
    ws_align = 1'b0;
    dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    repeat (3 * FRAME) @(negedge clk);

    // dvalid held high, data changing every cycle, occasional framing changes.
    dvalid = 1'b1;
    repeat (5 * FRAME) begin
      left_data = DW'($urandom);
      right_data = DW'($urandom);
      if ($urandom_range(0, 199) == 0) ws_align = ~ws_align;
      @(negedge clk);
    end
    dvalid = 1'b0;

    // Sparse random offers.
    repeat (4 * FRAME) begin
      dvalid = ($urandom_range(0, 79) == 0);
      left_data = DW'($urandom);
      right_data = DW'($urandom);
      if ($urandom_range(0, 149) == 0) ws_align = ~ws_align;
      @(negedge clk);
    end
    dvalid = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    // Offer exactly on a frame start with the holding register empty.
    for (int k = 0; k < FRAME && ((n + 1 - FIRST) % FRAME) != 0; k++) @(negedge clk);
    left_data = 16'h1234; right_data = 16'hBEEF; dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    chk("fs_offer_underrun", underrun, 1);
    chk("fs_offer_ready", ready, 0);
    repeat (2 * FRAME) @(negedge clk);

    // Load a pair mid-frame, then reset at bit_cnt = 7 so it is discarded.
    for (int k = 0; k < FRAME && ((n - FIRST) % FRAME) != 4 * CD + 1; k++) @(negedge clk);
    left_data = 16'hDEAD; right_data = 16'hCAFE; dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    for (int k = 0; k < FRAME && ((n - FIRST) % FRAME) != 7 * 2 * CD + 1; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ws_align = 1'b1;
    left_data = 16'hA5C3; right_data = 16'h0F0F;
    repeat (5) @(negedge clk);
    dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    repeat (3 * FRAME) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DW, default 16: sample width per channel in bits.
REQ-002 Parameter CLK_DIV, default 8: clk cycles per half bit-clock period; legal range is 1 or more.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 left_data  input  DW  left-channel sample, two's complement, MSB first on the wire.
REQ-006 right_data  input  DW  right-channel sample.
REQ-007 dvalid  input  1  the left/right pair is offered this cycle.
REQ-008 ready  output  1  the holding register is empty; a pair is accepted on dvalid && ready.
REQ-009 ws_align  input  1  framing select: 0 = standard I2S (WS leads data by one bit), 1 = left-justified.
REQ-010 i2s_clk  output  1  bit clock.
REQ-011 i2s_ws  output  1  word select: 0 = left channel, 1 = right channel.
REQ-012 i2s_dout  output  1  serial data.
REQ-013 underrun  output  1  one-cycle pulse when a frame starts with the holding register empty.

Function
REQ-014 Divider counter div_cnt counts 0..CLK_DIV-1 and wraps; i2s_clk toggles in the cycle div_cnt==CLK_DIV-1.
REQ-015 A "fall event" is an i2s_clk 1->0 toggle; i2s_ws and i2s_dout change only on fall events, so they are stable at every rising edge of i2s_clk.
REQ-016 bit_cnt spans 0..2*DW-1 and advances on each fall event, wrapping 2*DW-1 -> 0; a wrap to 0 is a "frame start".
REQ-017 At frame start, a 2*DW shift register loads {left,right} from the holding register, and ws_align is latched for that frame; a mid-frame change of ws_align has no effect until the next frame.
REQ-018 i2s_dout = shift register MSB; the register shifts left by one on each fall event that is not a frame start.
REQ-019 Left-justified frame: i2s_ws = 1 exactly while bit_cnt >= DW.
REQ-020 I2S frame: i2s_ws rises on the fall event that produces bit_cnt = DW-1 and falls on the fall event that produces bit_cnt = 2*DW-1, i.e. one bit ahead of the left-justified timing.
REQ-021 Holding register: ready = !full.
  - dvalid && ready sets full and captures both channels.
  - A frame start clears full.
REQ-022 A frame start consumes the holding-register state as registered before that cycle.
  - A dvalid accepted in the same cycle fills the holding register for the following frame.
  - If that holding-register state was empty, underrun pulses for 1 cycle.
REQ-023 Throughput is one pair per 2*DW*2*CLK_DIV clk cycles; a pair accepted at least 1 cycle before a frame start is on the wire from that frame start.

Reset
REQ-024 While rst = 1: div_cnt = 0, i2s_clk = 0, i2s_ws = 0, i2s_dout = 0, bit_cnt = 2*DW-1, shift register = 0, holding register = 0, full = 0 (ready = 1), underrun = 0.
REQ-025 After reset release, the first fall event occurs at the clk edge 2*CLK_DIV-1 cycles after the first non-reset edge, and it is a frame start.
REQ-026 Asserting rst mid-frame aborts the frame at the next clk edge and discards any held pair.

Configuration
REQ-027 With I2S_TX_UNDERRUN_MUTE_EN defined, an underrun frame transmits all zeros.
REQ-028 Without I2S_TX_UNDERRUN_MUTE_EN, an underrun frame retransmits the last accepted pair (zeros if none has been accepted since reset).
REQ-029 The underrun pulse behaves identically in both builds.

Structure
REQ-030 Shared package i2s_pkg holds the DW default, the ws_align encoding constants (I2S_STD = 0, I2S_LJ = 1) and the channel encoding (CH_LEFT = 0, CH_RIGHT = 1); i2s_rx uses the same package.
REQ-031 The divider and fall-event generation form sub-module i2s_bclk_gen (outputs i2s_clk and fall_evt); framing, shifting and holding logic stay in i2s_tx.

Verification
REQ-032 DW=16, CLK_DIV=2, ws_align=1; send L=16'hA5C3, R=16'h0F0F -> sampled on i2s_clk rising edges, the frame reads A5C3 then 0F0F, with i2s_ws = 0 for the first 16 bits and 1 for the last 16.
REQ-033 Same pair with ws_align=0 -> each i2s_ws edge precedes the channel's MSB by exactly one bit; a loopback into i2s_rx (ws_align=0) returns 16'hA5C3 and 16'h0F0F.
REQ-034 No dvalid after the first pair -> underrun pulses once per frame; the mute build outputs 32 zero bits, the non-mute build repeats A5C3/0F0F.
REQ-035 dvalid held high continuously -> ready is low for all but 1 cycle per frame, with one accepted pair per 128 clk cycles (DW=16, CLK_DIV=2), no loss and no duplicates.
REQ-036 dvalid in the same cycle as a frame start with the holding register empty -> underrun = 1, and that pair is transmitted in the next frame.
REQ-037 rst pulse at bit_cnt=7 -> all outputs match REQ-024 next cycle, and the first fall event follows REQ-025 timing.
